// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the FSM state enum, divide/branch opcodes and parameter defaults.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        BR_FLUSH = 2'd2
    } state_e;

    localparam logic [5:0] OP_DIV = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;

    localparam int FLUSH_CYCLES_DFLT   = 2;
    localparam int DIV_MAX_CYCLES_DFLT = 34;

    // Bits needed to hold values 0..n, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// master: datapath side (drives stage info); slave: controller side.
interface pipe_hazard_ctrl_if;

    logic [5:0] ID_OpCode;
    logic [4:0] ID_Rs;
    logic [4:0] ID_Rt;
    logic       EX_RegWrite;
    logic [4:0] EX_Rd;
    logic       MEM_Branch;
    logic       MEM_Bne;
    logic       MEM_Zero;
    logic       Div_Done;

    logic       Stall_IF;
    logic       Stall_ID;
    logic       Flush_ID;
    logic       Flush_EX;
    logic       PC_Src;
    logic       Div_Start;
    logic       Div_Abort;
    logic       Div_Err;

    modport master (
        output ID_OpCode, ID_Rs, ID_Rt, EX_RegWrite, EX_Rd,
        output MEM_Branch, MEM_Bne, MEM_Zero, Div_Done,
        input  Stall_IF, Stall_ID, Flush_ID, Flush_EX,
        input  PC_Src, Div_Start, Div_Abort, Div_Err
    );

    modport slave (
        input  ID_OpCode, ID_Rs, ID_Rt, EX_RegWrite, EX_Rd,
        input  MEM_Branch, MEM_Bne, MEM_Zero, Div_Done,
        output Stall_IF, Stall_ID, Flush_ID, Flush_EX,
        output PC_Src, Div_Start, Div_Abort, Div_Err
    );

endinterface

// File: rtl/pipe_hazard_ctrl_raw.sv
// RAW hazard compare between the EX destination and the ID sources.
// Ports: ex_reg_write/ex_rd (EX writer), id_rs/id_rt (ID readers), hazard.
module raw_hazard_detect (
    input  logic       ex_reg_write,
    input  logic [4:0] ex_rd,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);

    // r0 is hardwired zero, so writes to it never create a dependency.
    assign hazard = ex_reg_write && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs) || (ex_rd == id_rt));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: RAW stalls, divide wait/timeout, branch flush.
// Ports: Clk, Rst_n (sync, active-low), bus (slave side of the hazard bundle).
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DIV_MAX_CYCLES = DIV_MAX_CYCLES_DFLT,
    parameter int FLUSH_CYCLES   = FLUSH_CYCLES_DFLT
) (
    input  logic              Clk,
    input  logic              Rst_n,
    pipe_hazard_ctrl_if.slave bus
);

    localparam int WW = cnt_w(DIV_MAX_CYCLES);
    localparam int FW = cnt_w(FLUSH_CYCLES);

    localparam logic [WW-1:0] WAIT_LAST  = WW'(DIV_MAX_CYCLES - 1);
    localparam logic [FW-1:0] FLUSH_LOAD = FW'(FLUSH_CYCLES - 1);

    state_e        state_q, state_d;
    logic [WW-1:0] wait_q, wait_d;
    logic [FW-1:0] flush_q, flush_d;
    logic          err_q, err_d;

    logic taken;
    logic raw;

    logic stall_if, stall_id, flush_id, flush_ex;
    logic pc_src, div_start, div_abort;

    assign taken = bus.MEM_Branch & (bus.MEM_Zero ^ bus.MEM_Bne);

    raw_hazard_detect u_raw (
        .ex_reg_write (bus.EX_RegWrite),
        .ex_rd        (bus.EX_Rd),
        .id_rs        (bus.ID_Rs),
        .id_rt        (bus.ID_Rt),
        .hazard       (raw)
    );

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        flush_d   = flush_q;
        err_d     = err_q;
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        flush_id  = 1'b0;
        flush_ex  = 1'b0;
        pc_src    = 1'b0;
        div_start = 1'b0;
        div_abort = 1'b0;

        if (taken) begin
            // Branch outranks everything, including a divide in flight.
            pc_src    = 1'b1;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            div_abort = (state_q == DIV_WAIT);
            flush_d   = FLUSH_LOAD;
            state_d   = BR_FLUSH;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.ID_OpCode == OP_DIV) begin
                        div_start = 1'b1;
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        flush_ex  = 1'b1;
                        wait_d    = '0;
                        state_d   = DIV_WAIT;
                    end else if (raw) begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                DIV_WAIT: begin
                    if (wait_q != '1) begin
                        wait_d = wait_q + 1'b1;
                    end
                    if (bus.Div_Done) begin
                        // Release now so the divide advances exactly once.
                        state_d = RUN;
                    end else if (wait_q >= WAIT_LAST) begin
                        div_abort = 1'b1;
                        err_d     = 1'b1;
                        state_d   = RUN;
                    end else begin
                        stall_if = 1'b1;
                        stall_id = 1'b1;
                        flush_ex = 1'b1;
                    end
                end
                BR_FLUSH: begin
                    flush_id = 1'b1;
                    if (flush_q == '0) begin
                        state_d = RUN;
                    end else begin
                        flush_d = flush_q - 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end

        // Hold the front of the pipe empty while in reset.
        if (!Rst_n) begin
            stall_if  = 1'b0;
            stall_id  = 1'b0;
            flush_id  = 1'b1;
            flush_ex  = 1'b1;
            pc_src    = 1'b0;
            div_start = 1'b0;
            div_abort = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= RUN;
            wait_q  <= '0;
            flush_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            flush_q <= flush_d;
            err_q   <= err_d;
        end
    end

    assign bus.Stall_IF  = stall_if;
    assign bus.Stall_ID  = stall_id;
    assign bus.Flush_ID  = flush_id;
    assign bus.Flush_EX  = flush_ex;
    assign bus.PC_Src    = pc_src;
    assign bus.Div_Start = div_start;
    assign bus.Div_Abort = div_abort;
    assign bus.Div_Err   = err_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with default parameters.
// Output vector: {Stall_IF,Stall_ID,Flush_ID,Flush_EX,PC_Src,Div_Start,Div_Abort,Div_Err}.
module tb_pipe_hazard_ctrl;

    localparam logic [7:0] O_NONE  = 8'h00;
    localparam logic [7:0] O_STALL = 8'hD0;
    localparam logic [7:0] O_DSTRT = 8'hD4;
    localparam logic [7:0] O_TAKEN = 8'h38;
    localparam logic [7:0] O_TKABT = 8'h3A;
    localparam logic [7:0] O_FLUSH = 8'h20;
    localparam logic [7:0] O_RESET = 8'h30;
    localparam logic [7:0] O_ABORT = 8'h02;
    localparam logic [7:0] O_ERR   = 8'h01;

    logic Clk;
    logic Rst_n;
    int   n_cmp;
    int   n_bad;

    pipe_hazard_ctrl_if bus ();

    pipe_hazard_ctrl dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    logic [7:0] outs;
    assign outs = {bus.Stall_IF, bus.Stall_ID, bus.Flush_ID, bus.Flush_EX,
                   bus.PC_Src, bus.Div_Start, bus.Div_Abort, bus.Div_Err};

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Check at the negedge, then advance to just after the next posedge.
    task automatic step(input string tag, input logic [7:0] exp);
        @(negedge Clk);
        n_cmp++;
        assert (outs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %b expected %b", tag, outs, exp);
        end
        @(posedge Clk);
        #1;
    endtask

    task automatic idle_in();
        bus.ID_OpCode   = 6'h23;
        bus.ID_Rs       = 5'd1;
        bus.ID_Rt       = 5'd2;
        bus.EX_RegWrite = 1'b0;
        bus.EX_Rd       = 5'd0;
        bus.MEM_Branch  = 1'b0;
        bus.MEM_Bne     = 1'b0;
        bus.MEM_Zero    = 1'b0;
        bus.Div_Done    = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        Rst_n = 1'b0;
        idle_in();

        step("reset_0", O_RESET);
        step("reset_1", O_RESET);
        Rst_n = 1'b1;
        step("idle", O_NONE);

        bus.EX_RegWrite = 1'b1;
        bus.EX_Rd = 5'd5;
        bus.ID_Rs = 5'd5;
        step("raw_rs", O_STALL);
        idle_in();
        step("raw_release", O_NONE);

        bus.EX_RegWrite = 1'b1;
        bus.EX_Rd = 5'd7;
        bus.ID_Rt = 5'd7;
        step("raw_rt", O_STALL);

        bus.EX_Rd = 5'd0;
        bus.ID_Rs = 5'd0;
        bus.ID_Rt = 5'd0;
        step("raw_r0", O_NONE);

        bus.EX_RegWrite = 1'b0;
        bus.EX_Rd = 5'd5;
        bus.ID_Rs = 5'd5;
        step("raw_nowrite", O_NONE);
        idle_in();

        bus.MEM_Branch = 1'b1;
        bus.MEM_Bne = 1'b1;
        bus.MEM_Zero = 1'b1;
        step("bne_not_taken", O_NONE);
        bus.MEM_Zero = 1'b0;
        step("bne_taken", O_TAKEN);
        idle_in();
        step("bne_flush1", O_FLUSH);
        step("bne_flush2", O_FLUSH);
        step("bne_done", O_NONE);

        bus.MEM_Branch = 1'b1;
        bus.MEM_Zero = 1'b1;
        step("beq_taken", O_TAKEN);
        idle_in();
        bus.EX_RegWrite = 1'b1;
        bus.EX_Rd = 5'd1;
        step("beq_flush1", O_FLUSH);
        idle_in();
        step("beq_flush2", O_FLUSH);
        step("beq_done", O_NONE);

        bus.ID_OpCode = 6'b000000;
        step("div_start", O_DSTRT);
        for (int i = 0; i < 9; i++) step("div_wait", O_STALL);
        bus.Div_Done = 1'b1;
        step("div_done", O_NONE);
        idle_in();
        step("div_no_reissue", O_NONE);

        bus.ID_OpCode = 6'b000000;
        step("bd_start", O_DSTRT);
        step("bd_wait1", O_STALL);
        step("bd_wait2", O_STALL);
        bus.MEM_Branch = 1'b1;
        bus.MEM_Zero = 1'b1;
        step("bd_branch", O_TKABT);
        idle_in();
        step("bd_flush1", O_FLUSH);
        step("bd_flush2", O_FLUSH);
        step("bd_done", O_NONE);

        bus.ID_OpCode = 6'b000000;
        step("bdd_start", O_DSTRT);
        bus.Div_Done = 1'b1;
        bus.MEM_Branch = 1'b1;
        bus.MEM_Zero = 1'b1;
        step("bdd_branch_wins", O_TKABT);
        idle_in();
        step("bdd_flush1", O_FLUSH);
        step("bdd_flush2", O_FLUSH);
        step("bdd_done", O_NONE);

        bus.ID_OpCode = 6'b000000;
        step("rd_start", O_DSTRT);
        step("rd_wait1", O_STALL);
        Rst_n = 1'b0;
        step("rd_reset", O_RESET);
        Rst_n = 1'b1;
        idle_in();
        step("rd_run", O_NONE);

        bus.ID_OpCode = 6'b000000;
        step("to_start", O_DSTRT);
        for (int i = 0; i < 33; i++) step("to_wait", O_STALL);
        step("to_abort", O_ABORT);
        idle_in();
        step("to_err", O_ERR);
        step("to_err_sticky", O_ERR);
        bus.EX_RegWrite = 1'b1;
        bus.EX_Rd = 5'd2;
        step("to_err_raw", O_STALL | O_ERR);
        idle_in();

        Rst_n = 1'b0;
        @(posedge Clk);
        #1;
        step("err_reset", O_RESET);
        Rst_n = 1'b1;
        step("err_cleared", O_NONE);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 The block SHALL have parameter DIV_MAX_CYCLES, default 34: the number of cycles spent waiting for a divide result before the wait is aborted.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 2: the number of cycles Flush_ID is held after a taken branch.
REQ-003 The block SHALL have port Clk, input, 1 bit: the single clock. State updates on posedge; outputs are valid before the negedge write of the pipeline registers.
REQ-004 The block SHALL have port Rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port ID_OpCode, input, 6 bits: opcode in the ID stage.
REQ-006 The block SHALL have ports ID_Rs and ID_Rt, input, 5 bits each: ID source registers.
REQ-007 The block SHALL have ports EX_RegWrite (1 bit) and EX_Rd (5 bits), inputs: the write enable and destination register of the instruction in EX.
REQ-008 The block SHALL have ports MEM_Branch, MEM_Bne and MEM_Zero, inputs, 1 bit each: branch controls from the EX/MEM register.
REQ-009 The block SHALL have port Div_Done, input, 1 bit: divider result valid.
REQ-010 The block SHALL have output Stall_IF, 1 bit: hold the PC and IF/ID register.
REQ-011 The block SHALL have output Stall_ID, 1 bit: hold the ID stage.
REQ-012 The block SHALL have output Flush_ID, 1 bit: zero the IF/ID register.
REQ-013 The block SHALL have output Flush_EX, 1 bit: insert a bubble into ID/EX.
REQ-014 The block SHALL have output PC_Src, 1 bit: select the branch target.
REQ-015 The block SHALL have output Div_Start, 1 bit: a one-cycle divider start pulse.
REQ-016 The block SHALL have output Div_Abort, 1 bit: a one-cycle divider cancel pulse.
REQ-017 The block SHALL have output Div_Err, 1 bit: sticky divide-timeout flag.

Function
REQ-018 The block SHALL have states RUN, DIV_WAIT and BR_FLUSH, and SHALL decode all outputs except Div_Err combinationally (Mealy) from the state and the inputs.
REQ-019 The block SHALL compute the branch-taken signal as MEM_Branch & (MEM_Zero ^ MEM_Bne).
REQ-020 In any state, branch taken SHALL assert PC_Src, Flush_ID and Flush_EX that cycle, load the flush counter with FLUSH_CYCLES-1, and move to BR_FLUSH; branch taken SHALL have highest priority.
REQ-021 In BR_FLUSH, the block SHALL assert Flush_ID and decrement the counter each cycle, and SHALL move to RUN in the cycle after the counter reads 0; FLUSH_CYCLES=1 SHALL mean one flush cycle only.
REQ-022 In RUN, with no branch taken and ID_OpCode=6'b000000, the block SHALL pulse Div_Start, assert Stall_IF, Stall_ID and Flush_EX, clear the wait counter, and move to DIV_WAIT.
REQ-023 In DIV_WAIT, the block SHALL assert Stall_IF, Stall_ID and Flush_EX and increment the wait counter each cycle.
REQ-024 In DIV_WAIT, Div_Done=1 SHALL deassert all stall and flush outputs that same cycle and move the block to RUN, so the divide advances exactly once and is not reissued.
REQ-025 In DIV_WAIT, if the wait counter reaches DIV_MAX_CYCLES-1 without Div_Done, the block SHALL pulse Div_Abort, set Div_Err, deassert the stalls, and move to RUN.
REQ-026 A branch taken while in DIV_WAIT SHALL pulse Div_Abort and follow REQ-020.
REQ-027 If Div_Done and branch taken occur together, the branch SHALL win and Div_Abort SHALL pulse.
REQ-028 In RUN, with no branch and no divide, the block SHALL detect a RAW hazard as EX_RegWrite & (EX_Rd != 0) & (EX_Rd == ID_Rs | EX_Rd == ID_Rt).
REQ-029 On a RAW hazard, the block SHALL assert Stall_IF, Stall_ID and Flush_EX for that cycle only and remain in RUN.
REQ-030 A write to register 0 SHALL never stall.
REQ-031 When no condition applies, all outputs SHALL be 0.
REQ-032 The wait counter SHALL be wide enough for DIV_MAX_CYCLES and SHALL saturate rather than wrap.
REQ-033 Div_Err SHALL be a register, cleared only by reset.

Reset
REQ-034 With Rst_n=0 at a posedge, the block SHALL go to state RUN, clear both counters and clear Div_Err.
REQ-035 While Rst_n=0, Flush_ID and Flush_EX SHALL be 1 and all other outputs 0.
REQ-036 Reset asserted during DIV_WAIT or BR_FLUSH SHALL abandon the operation without a Div_Abort pulse.

Structure
REQ-037 Package pipe_ctrl_pkg SHALL hold the state enum, OP_DIV=6'b000000, OP_BEQ=6'b000100, OP_BNE=6'b000101, and the FLUSH_CYCLES and DIV_MAX_CYCLES defaults.
REQ-038 The RAW comparison of REQ-028 SHALL be implemented in one combinational sub-module, raw_hazard_detect; the FSM and counters SHALL stay in the top level.

Verification
REQ-039 Scenario, RAW stall: EX_RegWrite=1, EX_Rd=5, ID_Rs=5 -> Stall_IF=Stall_ID=Flush_EX=1 for one cycle; the same stimulus with EX_Rd=0 -> no stall.
REQ-040 Scenario, divide: ID_OpCode=000000, Div_Done returned after 10 cycles -> Div_Start pulses once, stalls held 10 cycles then released, Div_Err=0.
REQ-041 Scenario, divide timeout: DIV_MAX_CYCLES=34 and Div_Done held at 0 -> Div_Abort on wait cycle 34, Div_Err=1 until reset.
REQ-042 Scenario, branches: MEM_Branch=1, MEM_Bne=0, MEM_Zero=1 -> PC_Src=1, Flush_ID held 2 cycles; MEM_Bne=1, MEM_Zero=1 -> no flush.
REQ-043 Scenario, branch during divide: branch taken in wait cycle 3 -> Div_Abort=1 and PC_Src=1 in the same cycle; branch taken together with Div_Done -> the branch wins.
REQ-044 Scenario, reset mid-divide: Rst_n=0 in DIV_WAIT -> state RUN, Flush_ID=Flush_EX=1, Div_Abort=0, Div_Err=0.
